// File: rtl/dmem_cache_if.sv
// Core-side request/response and backing-memory req/ack signals of the data cache.
// No storage; purely a signal bundle.
// The slave modport is the cache view; master is the core plus backing memory.
interface dmem_cache_if;
  // Core side
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] data_out;
  logic        ready;
  logic        miss;
  // Backing-memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  addr, data_in, write_enable, read_enable, mem_rdata, mem_ack,
    output data_out, ready, miss, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, data_in, write_enable, read_enable, mem_rdata, mem_ack,
    input  data_out, ready, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill.
// Latency: read hit 1 cycle; read miss refills LINE_WORDS words; write waits for one backing ack.
// Backpressure: ready low (miss high) while refilling or writing through; requests then are ignored.
module dmem_cache #(
  parameter int INDEX_BITS = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       rstn,
  dmem_cache_if.slave bus
);
  localparam int OFF       = $clog2(LINE_WORDS);
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_BITS  = 30 - OFF - INDEX_BITS;
  localparam int RAM_AW    = INDEX_BITS + OFF;
  localparam int RAM_WORDS = 1 << RAM_AW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                 state_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_q [LINES];
  logic [31:0]            ram [RAM_WORDS];

  // Refill bookkeeping
  logic [OFF-1:0]         k_q;
  logic [OFF-1:0]         req_word_q;
  logic [INDEX_BITS-1:0]  fill_idx_q;
  logic [TAG_BITS-1:0]    fill_tag_q;

  // Registered outputs
  logic [31:0]            data_out_q;
  logic                   miss_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [31:0]            mem_addr_q;
  logic [31:0]            mem_wdata_q;

  // Request address decode
  logic [OFF-1:0]         req_word;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [31:0]            line_base;
  logic                   hit;
  logic                   refill_last;
  logic                   unused_addr_bits;

  assign req_word  = bus.addr[2+OFF-1:2];
  assign req_idx   = bus.addr[2+OFF+INDEX_BITS-1:2+OFF];
  assign req_tag   = bus.addr[31:2+OFF+INDEX_BITS];
  assign line_base = {bus.addr[31:2+OFF], {(OFF+2){1'b0}}};
  assign unused_addr_bits = ^bus.addr[1:0];

  // An invalid line never hits, whatever its stale tag says.
  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign refill_last = (state_q == REFILL) && bus.mem_ack && (k_q == {OFF{1'b1}});

  assign bus.ready     = (state_q == IDLE);
  assign bus.miss      = miss_q;
  assign bus.data_out  = data_out_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Data RAM write port: store hits in IDLE, acked refill words in REFILL.
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [31:0]       ram_wdata;

  // Select the RAM write source for this cycle.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {req_idx, req_word};
    ram_wdata = bus.data_in;
    if (state_q == IDLE) begin
      ram_we = bus.write_enable && hit;
    end else if (state_q == REFILL) begin
      ram_we    = bus.mem_ack;
      ram_waddr = {fill_idx_q, k_q};
      ram_wdata = bus.mem_rdata;
    end
  end

  // Data RAM write.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Tag is committed only once the whole line has arrived.
  always_ff @(posedge clk) begin
    if (refill_last) tag_q[fill_idx_q] <= fill_tag_q;
  end

  // Control FSM with registered outputs, valid bits and the load-data register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      k_q         <= '0;
      req_word_q  <= '0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
      data_out_q  <= '0;
      miss_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.write_enable) begin
            // Write wins when both enables are set; RAM hit update happens this edge.
            state_q     <= WRITE;
            miss_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.addr[31:2], 2'b00};
            mem_wdata_q <= bus.data_in;
          end else if (bus.read_enable) begin
            if (hit) begin
              data_out_q <= ram[{req_idx, req_word}];
            end else begin
              state_q    <= REFILL;
              miss_q     <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_base;
              k_q        <= '0;
              req_word_q <= req_word;
              fill_idx_q <= req_idx;
              fill_tag_q <= req_tag;
              // Drop the victim now so an aborted refill leaves the line invalid.
              valid_q[req_idx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            if (k_q == req_word_q) data_out_q <= bus.mem_rdata;
            if (k_q == {OFF{1'b1}}) begin
              valid_q[fill_idx_q] <= 1'b1;
              state_q   <= IDLE;
              miss_q    <= 1'b0;
              mem_req_q <= 1'b0;
            end else begin
              k_q        <= k_q + OFF'(1);
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            state_q   <= IDLE;
            miss_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_cache.sv
// Scoreboard bench for dmem_cache: directed requests push expected backing
// transactions, stall lengths and load data; monitors pop and compare.
module tb_dmem_cache;
  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   ack_dly = 0;

  dmem_cache_if bus();

  dmem_cache #(.INDEX_BITS(8), .LINE_WORDS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_t;

  mem_t        exp_mem[$];
  logic [31:0] exp_rd[$];
  int          exp_stall[$];
  logic [31:0] store [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  // Backing memory responder; also checks each transaction at its ack.
  initial begin : responder
    int   wcnt;
    mem_t e;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= ack_dly) begin
        bus.mem_ack = 1'b1;
        wcnt = 0;
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got we=%b addr=%h want none", bus.mem_we, bus.mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
          chk("mem_addr", bus.mem_addr, e.addr);
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
        end
        if (bus.mem_we) store[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = model(bus.mem_addr);
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Load-data and stall-length monitor.
  initial begin : monitor
    bit          rd_pend;
    int          miss_cnt;
    logic [31:0] er;
    int          es;
    rd_pend  = 1'b0;
    miss_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        rd_pend  = 1'b0;
        miss_cnt = 0;
      end else begin
        if (rd_pend && bus.ready) begin
          rd_pend = 1'b0;
          if (exp_rd.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got %h want none", bus.data_out);
          end else begin
            er = exp_rd.pop_front();
            chk("data_out", bus.data_out, er);
          end
        end
        if (bus.miss) miss_cnt++;
        else if (miss_cnt > 0) begin
          if (exp_stall.size() == 0) begin
            total++; bad++;
            $display("FAIL stall_unexpected: got %0d cycles want none", miss_cnt);
          end else begin
            es = exp_stall.pop_front();
            chk("miss_cycles", miss_cnt, es);
          end
          miss_cnt = 0;
        end
        if (bus.ready && bus.read_enable && !bus.write_enable) rd_pend = 1'b1;
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: got ready=0 want ready=1 for addr %h", a);
      return;
    end
    bus.addr         = a;
    bus.data_in      = d;
    bus.write_enable = w;
    bus.read_enable  = ~w;
    @(posedge clk); #2;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.ready) begin
      total++; bad++;
      $display("FAIL idle_timeout: got ready=0 want ready=1");
    end
  endtask

  task automatic exp_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_mem.push_back('{1'b0, base + 32'(4 * k), 32'h0});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rstn             = 1'b0;
    bus.addr         = '0;
    bus.data_in      = '0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_miss", {31'b0, bus.miss}, 32'd0);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #2;

    // Cold read miss with ack every cycle; requests during the stall are ignored.
    exp_line(32'h100);
    exp_stall.push_back(4);
    exp_rd.push_back(32'hA2);
    issue(1'b0, 32'h108, 32'h0);
    bus.addr = 32'h500; bus.data_in = 32'h55; bus.write_enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    bus.write_enable = 1'b0;
    wait_idle();

    // Back-to-back hits
    exp_rd.push_back(32'hA0);
    exp_rd.push_back(32'hA3);
    issue(1'b0, 32'h100, 32'h0);
    issue(1'b0, 32'h10C, 32'h0);

    // Write hit with delayed ack, then read it back
    ack_dly = 2;
    exp_mem.push_back('{1'b1, 32'h104, 32'hDEADBEEF});
    exp_stall.push_back(3);
    issue(1'b1, 32'h104, 32'hDEADBEEF);
    wait_idle();
    chk("data_out_hold_after_write", bus.data_out, 32'hA3);
    ack_dly = 0;
    exp_rd.push_back(32'hDEADBEEF);
    issue(1'b0, 32'h104, 32'h0);

    // Write miss: no allocate, so the next read of it refills
    exp_mem.push_back('{1'b1, 32'h204, 32'h12345678});
    exp_stall.push_back(1);
    issue(1'b1, 32'h204, 32'h12345678);
    exp_line(32'h200);
    exp_stall.push_back(4);
    exp_rd.push_back(32'h12345678);
    issue(1'b0, 32'h204, 32'h0);

    // Conflict eviction of line 0x100
    exp_line(32'h1100);
    exp_stall.push_back(4);
    exp_rd.push_back(32'h4A0);
    issue(1'b0, 32'h1100, 32'h0);
    exp_line(32'h100);
    exp_stall.push_back(4);
    exp_rd.push_back(32'hA0);
    issue(1'b0, 32'h100, 32'h0);
    exp_rd.push_back(32'hDEADBEEF);
    issue(1'b0, 32'h104, 32'h0);
    wait_idle();

    // Reset in the middle of a refill, after two acks
    exp_mem.push_back('{1'b0, 32'h300, 32'h0});
    exp_mem.push_back('{1'b0, 32'h304, 32'h0});
    issue(1'b0, 32'h308, 32'h0);
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk); #1;
      if (bus.mem_req && bus.mem_ack) n++;
    end
    chk("abort_acks_seen", n, 32'd2);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("abort_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("abort_ready", {31'b0, bus.ready}, 32'd1);
    chk("abort_miss", {31'b0, bus.miss}, 32'd0);
    chk("abort_data_out", bus.data_out, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk); #2;
    exp_line(32'h300);
    exp_stall.push_back(4);
    exp_rd.push_back(32'h122);
    issue(1'b0, 32'h308, 32'h0);
    exp_line(32'h100);
    exp_stall.push_back(4);
    exp_rd.push_back(32'hA0);
    issue(1'b0, 32'h100, 32'h0);
    wait_idle();
    repeat (3) @(posedge clk);
    #2;

    chk("exp_mem_left", exp_mem.size(), 32'd0);
    chk("exp_rd_left", exp_rd.size(), 32'd0);
    chk("exp_stall_left", exp_stall.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
